// File: rtl/arb_priority_rr8_if.sv
// Request/grant bundle between the clients and the eight-way arbiter.
// The master side drives requests and mode; the slave (arbiter) returns the grant.
interface arb_priority_rr8_if #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3
) ();
  logic [NUM_REQ-1:0] req;
  logic               mode;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output req, mode,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, mode,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/arb_priority_rr8.sv
// Eight-requester arbiter with fixed-priority / round-robin selection,
// hold-until-release ownership and a bounded hold time. All outputs registered.
module arb_priority_rr8 #(
  parameter int NUM_REQ  = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  arb_priority_rr8_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t             state, state_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               vld_q, vld_n;
  logic               tmo_q, tmo_n;
  logic [IDX_W-1:0]   ptr_q, ptr_n;
  logic [7:0]         hold_q, hold_n;

  logic [NUM_REQ-1:0] others;
  logic               do_grant;
  logic [IDX_W-1:0]   grant_i;

  // mode 0: highest set bit; mode 1: first set bit searching down from p, wrapping
  function automatic logic [IDX_W-1:0] win(input logic [NUM_REQ-1:0] mask,
                                           input logic m,
                                           input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] r;
    logic [IDX_W-1:0] c;
    logic             hit;
    r   = '0;
    c   = '0;
    hit = 1'b0;
    if (!m) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (mask[i]) r = IDX_W'(i);
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        c = p - IDX_W'(k);
        if (!hit && mask[c]) begin
          r   = c;
          hit = 1'b1;
        end
      end
    end
    return r;
  endfunction

  assign others = bus.req & ~(NUM_REQ'(1) << idx_q);

  always_comb begin
    state_n  = state;
    gnt_n    = gnt_q;
    idx_n    = idx_q;
    vld_n    = vld_q;
    tmo_n    = 1'b0;
    ptr_n    = ptr_q;
    hold_n   = hold_q;
    do_grant = 1'b0;
    grant_i  = '0;

    case (state)
      IDLE: begin
        if (bus.req != '0) begin
          do_grant = 1'b1;
          grant_i  = win(bus.req, bus.mode, ptr_q);
        end
      end
      GRANT: begin
        if (bus.req[idx_q]) begin
          if (hold_q < HOLD_MAX) begin
            hold_n = hold_q + 8'd1;
          end else if (others != '0) begin
            do_grant = 1'b1;
            grant_i  = win(others, bus.mode, ptr_q);
            tmo_n    = 1'b1;
          end else begin
            hold_n = 8'd1;
          end
        end else if (bus.req != '0) begin
          do_grant = 1'b1;
          grant_i  = win(bus.req, bus.mode, ptr_q);
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
          idx_n   = '0;
          vld_n   = 1'b0;
          hold_n  = 8'd0;
        end
      end
      default: state_n = IDLE;
    endcase

    // every grant, forced or not, moves the round-robin pointer just below the winner
    if (do_grant) begin
      state_n = GRANT;
      gnt_n   = NUM_REQ'(1) << grant_i;
      idx_n   = grant_i;
      vld_n   = 1'b1;
      ptr_n   = grant_i - IDX_W'(1);
      hold_n  = 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt_q  <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      tmo_q  <= 1'b0;
      ptr_q  <= IDX_W'(NUM_REQ - 1);
      hold_q <= 8'd0;
    end else begin
      state  <= state_n;
      gnt_q  <= gnt_n;
      idx_q  <= idx_n;
      vld_q  <= vld_n;
      tmo_q  <= tmo_n;
      ptr_q  <= ptr_n;
      hold_q <= hold_n;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = vld_q;
  assign bus.timeout   = tmo_q;

endmodule

// File: tb/tb_arb_priority_rr8.sv
// Directed bench for arb_priority_rr8: one instance with the default hold limit
// and one with a hold limit of 4 for the forced-handoff cases.
module tb_arb_priority_rr8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  arb_priority_rr8_if #(.NUM_REQ(8), .IDX_W(3)) ifa ();
  arb_priority_rr8_if #(.NUM_REQ(8), .IDX_W(3)) ifb ();

  arb_priority_rr8 #(.NUM_REQ(8), .IDX_W(3), .MAX_HOLD(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  arb_priority_rr8 #(.NUM_REQ(8), .IDX_W(3), .MAX_HOLD(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [2:0] idx, input logic [7:0] g, input logic v);
    chk({tag, ".idx"}, {5'b0, ifa.gnt_idx}, {5'b0, idx});
    chk({tag, ".gnt"}, ifa.gnt, g);
    chk({tag, ".vld"}, {7'b0, ifa.gnt_valid}, {7'b0, v});
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    ifa.req  = 8'hFF;
    ifa.mode = 1'b0;
    ifb.req  = 8'h00;
    ifb.mode = 1'b0;

    // reset with all requests active
    step();
    step();
    chk_a("rst", 3'd0, 8'h00, 1'b0);
    chk("rst.tmo", {7'b0, ifa.timeout}, 8'h00);

    rst_n = 1'b1;
    step();
    chk_a("first_fixed", 3'd7, 8'h80, 1'b1);

    // fixed-priority release chain
    ifa.req = 8'b0010_0101; step(); chk_a("fix5", 3'd5, 8'h20, 1'b1);
    ifa.req = 8'b0000_0101; step(); chk_a("fix2", 3'd2, 8'h04, 1'b1);
    ifa.req = 8'b0000_0001; step(); chk_a("fix0", 3'd0, 8'h01, 1'b1);
    ifa.req = 8'b0000_0000; step(); chk_a("fixidle", 3'd0, 8'h00, 1'b0);

    // round-robin alternation after a fresh reset
    rst_n = 1'b0; step(); rst_n = 1'b1;
    ifa.mode = 1'b1;
    ifa.req = 8'b1000_0001; step(); chk_a("rr_a", 3'd7, 8'h80, 1'b1);
    ifa.req = 8'b0000_0001; step(); chk_a("rr_b", 3'd0, 8'h01, 1'b1);
    ifa.req = 8'b1000_0000; step(); chk_a("rr_c", 3'd7, 8'h80, 1'b1);
    ifa.req = 8'b0000_0001; step(); chk_a("rr_d", 3'd0, 8'h01, 1'b1);

    // reach owner 4 in round-robin, then reset mid-grant
    ifa.req = 8'b0001_0000; step(); chk_a("rr_own4", 3'd4, 8'h10, 1'b1);
    rst_n = 1'b0; step();
    chk_a("midrst", 3'd0, 8'h00, 1'b0);
    chk("midrst.tmo", {7'b0, ifa.timeout}, 8'h00);
    rst_n = 1'b1;
    ifa.req = 8'b0001_0001; step(); chk_a("ptr_reset", 3'd4, 8'h10, 1'b1);

    // pointer at 3 then 1: round-robin picks below, not the highest index
    ifa.req = 8'b0000_0101; step(); chk_a("rr_ptr3", 3'd2, 8'h04, 1'b1);
    ifa.req = 8'b1000_0011; step(); chk_a("rr_ptr1", 3'd1, 8'h02, 1'b1);

    // everything drops while owned
    ifa.req = 8'b0000_0000; step(); chk_a("empty", 3'd0, 8'h00, 1'b0);

    // owner releases as a new request appears in the same cycle
    ifa.req = 8'b0000_0001; step(); chk_a("own0", 3'd0, 8'h01, 1'b1);
    ifa.req = 8'b0100_0000; step(); chk_a("simul6", 3'd6, 8'h40, 1'b1);
    ifa.req = 8'b0000_0000; step(); chk_a("simul_idle", 3'd0, 8'h00, 1'b0);

    // forced handoff with hold limit 4
    ifb.req = 8'b0000_1000; step();
    chk("to_h1", {5'b0, ifb.gnt_idx}, 8'd3);
    ifb.req = 8'b0000_1010;
    step(); chk("to_h2", {5'b0, ifb.gnt_idx}, 8'd3);
    chk("to_h2.tmo", {7'b0, ifb.timeout}, 8'h00);
    step(); chk("to_h3", {5'b0, ifb.gnt_idx}, 8'd3);
    step(); chk("to_h4", {5'b0, ifb.gnt_idx}, 8'd3);
    chk("to_h4.tmo", {7'b0, ifb.timeout}, 8'h00);
    step(); chk("to_force", {5'b0, ifb.gnt_idx}, 8'd1);
    chk("to_force.gnt", ifb.gnt, 8'h02);
    chk("to_force.tmo", {7'b0, ifb.timeout}, 8'h01);
    step(); chk("to_after", {5'b0, ifb.gnt_idx}, 8'd1);
    chk("to_after.tmo", {7'b0, ifb.timeout}, 8'h00);

    // lone requester past the hold limit keeps the grant
    ifb.req = 8'b0000_1000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("alone.idx", {5'b0, ifb.gnt_idx}, 8'd3);
      chk("alone.tmo", {7'b0, ifb.timeout}, 8'h00);
    end
    ifb.req = 8'b0000_0000; step();
    chk("b_idle", {7'b0, ifb.gnt_valid}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
